// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared gray-code helpers and checker state type
//
// Purpose : gray/binary conversion, popcount and the checker state enum.
//           Helpers operate on a GC_MAX_W-bit word. Callers zero-extend
//           narrower codes, which decode correctly because the gray prefix
//           XOR from the MSB is unaffected by leading zeros.
// Ports   : none (package)

package gray_pkg;

    localparam int GC_MAX_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } gc_state_t;

    // Binary bit i is the XOR of all gray bits at or above i.
    function automatic logic [GC_MAX_W-1:0] gray2bin(input logic [GC_MAX_W-1:0] g);
        logic [GC_MAX_W-1:0] b;
        b[GC_MAX_W-1] = g[GC_MAX_W-1];
        for (int i = GC_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GC_MAX_W-1:0] bin2gray(input logic [GC_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned popcount(input logic [GC_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < GC_MAX_W; i++) begin
            n += {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_seq_checker.sv
// rtl/gray_seq_checker.sv - gray-code sequence checker for an upstream gray counter
//
// Purpose : samples gray_in on enabled clocks, decodes it and verifies each
//           change is a single-bit +1 step (mod 2^WIDTH). Reports step pulses,
//           wrap and a saturating error count.
// Ports   : clk       - rising-edge clock
//           rst_n     - asynchronous active-low reset
//           en        - sample strobe
//           clr       - synchronous resync to IDLE, clears err_count (wins over en)
//           gray_in   - gray code from upstream counter
//           bin_out   - binary decode of last accepted sample
//           locked    - high while tracking
//           step_ok   - pulse: legal +1 step
//           step_err  - pulse: illegal change
//           wrap      - pulse: legal step from all-ones to zero
//           err_count - saturating count of step_err events
// WIDTH must be in 2..GC_MAX_W.

module gray_seq_checker
    import gray_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     gray_in,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 locked,
    output logic                 step_ok,
    output logic                 step_err,
    output logic                 wrap,
    output logic [ERR_CNT_W-1:0] err_count
);

    gc_state_t        state_q;
    logic [WIDTH-1:0] prev_gray_q;

    logic [GC_MAX_W-1:0] new_ext;
    logic [GC_MAX_W-1:0] old_ext;
    logic [WIDTH-1:0]    b_new;
    logic [WIDTH-1:0]    b_old;
    logic [WIDTH-1:0]    b_old_inc;
    logic                one_bit_change;
    logic                is_hold;
    logic                is_legal;
    logic                old_is_max;

    always_comb begin
        new_ext        = GC_MAX_W'(gray_in);
        old_ext        = GC_MAX_W'(prev_gray_q);
        b_new          = WIDTH'(gray2bin(new_ext));
        b_old          = WIDTH'(gray2bin(old_ext));
        // Natural WIDTH-bit wrap gives the modulo for free.
        b_old_inc      = b_old + WIDTH'(1);
        one_bit_change = (popcount(new_ext ^ old_ext) == 1);
        is_hold        = (gray_in == prev_gray_q);
        is_legal       = one_bit_change && (b_new == b_old_inc);
        old_is_max     = (b_old == {WIDTH{1'b1}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prev_gray_q <= '0;
            bin_out     <= '0;
            locked      <= 1'b0;
            step_ok     <= 1'b0;
            step_err    <= 1'b0;
            wrap        <= 1'b0;
            err_count   <= '0;
        end else begin
            // Pulses default low; only an accepted non-hold sample raises one.
            step_ok  <= 1'b0;
            step_err <= 1'b0;
            wrap     <= 1'b0;

            if (clr) begin
                // bin_out and prev_gray intentionally retained; the next
                // enabled sample re-locks and overwrites them.
                state_q   <= IDLE;
                locked    <= 1'b0;
                err_count <= '0;
            end else if (en) begin
                case (state_q)
                    IDLE: begin
                        prev_gray_q <= gray_in;
                        bin_out     <= b_new;
                        state_q     <= TRACK;
                        locked      <= 1'b1;
                    end
                    TRACK: begin
                        if (!is_hold) begin
                            // Legal or not, resynchronise to the new value.
                            prev_gray_q <= gray_in;
                            bin_out     <= b_new;
                            if (is_legal) begin
                                step_ok <= 1'b1;
                                wrap    <= old_is_max;
                            end else begin
                                step_err <= 1'b1;
                                if (err_count != {ERR_CNT_W{1'b1}}) begin
                                    err_count <= err_count + ERR_CNT_W'(1);
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
